// File: rtl/jk_mod_counter_drv.sv
`default_nettype none
// ============================================================================
// Module      : jk_mod_counter_drv
// Description : Modulo-MOD up/down counter emitting J/K excitation for an
//               external, reset-less JK flip-flop bank that mirrors the count.
// Revision    : 1.0 - initial release
// ============================================================================
module jk_mod_counter_drv #(
    parameter int WIDTH = 4,
    parameter int MOD   = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] j_out,
    output logic [WIDTH-1:0] k_out,
    output logic             tc,
    output logic             synced
);

    typedef enum logic [0:0] {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // Terminal value kept one bit wider so MOD = 2**WIDTH cannot overflow.
    localparam logic [WIDTH:0]   c_max_ext = (WIDTH+1)'(MOD - 1);
    localparam logic [WIDTH-1:0] c_max     = c_max_ext[WIDTH-1:0];

    state_t           r_state;
    logic [WIDTH-1:0] r_count;
    logic             r_synced;
    logic [WIDTH-1:0] w_nxt;
    logic [WIDTH-1:0] w_toggle;
    logic             w_force;

    always_comb begin
        w_nxt = r_count;
        if (load) begin
            w_nxt = ({1'b0, load_val} > c_max_ext) ? c_max : load_val;
        end else if (en && up_dn) begin
            w_nxt = ({1'b0, r_count} == c_max_ext) ? '0 : r_count + 1'b1;
        end else if (en) begin
            w_nxt = (r_count == '0) ? c_max : r_count - 1'b1;
        end
    end

    assign w_toggle = r_count ^ w_nxt;
    assign w_force  = (r_state == S_INIT) || load;

    // Force mode sets/clears every bit; toggle mode flips only changing bits.
    always_comb begin
        j_out = '0;
        k_out = '0;
        if (rst_n) begin
            if (w_force) begin
                j_out = w_nxt;
                k_out = ~w_nxt;
            end else begin
                j_out = w_toggle;
                k_out = w_toggle;
            end
        end
    end

    assign tc = en && !load &&
                ((up_dn && (r_count == c_max)) || (!up_dn && (r_count == '0)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count  <= '0;
            r_state  <= S_INIT;
            r_synced <= 1'b0;
        end else begin
            r_count <= w_nxt;
            case (r_state)
                S_INIT: begin
                    r_state  <= S_RUN;
                    r_synced <= 1'b1;
                end
                S_RUN:   r_state <= S_RUN;
                default: r_state <= S_INIT;
            endcase
        end
    end

    assign count  = r_count;
    assign synced = r_synced;

endmodule
`default_nettype wire

// File: tb/tb_jk_mod_counter_drv.sv
`default_nettype none
// ============================================================================
// Module      : tb_jk_mod_counter_drv
// Description : Scoreboard bench with a behavioural counter model and a
//               model of the downstream JK flip-flop bank.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jk_mod_counter_drv;

    localparam int WIDTH = 4;
    localparam int MOD   = 10;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic             up_dn;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] j_out;
    logic [WIDTH-1:0] k_out;
    logic             tc;
    logic             synced;

    jk_mod_counter_drv #(.WIDTH(WIDTH), .MOD(MOD)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .up_dn    (up_dn),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .j_out    (j_out),
        .k_out    (k_out),
        .tc       (tc),
        .synced   (synced)
    );

    always #5 clk = ~clk;

    // Downstream JK bank: no reset, starts from arbitrary contents.
    logic [WIDTH-1:0] bank = 4'b1011;
    always @(posedge clk) begin
        for (int b = 0; b < WIDTH; b++) begin
            case ({j_out[b], k_out[b]})
                2'b01:   bank[b] <= 1'b0;
                2'b10:   bank[b] <= 1'b1;
                2'b11:   bank[b] <= ~bank[b];
                default: ;
            endcase
        end
    end

    typedef struct {
        logic [WIDTH-1:0] cnt;
        logic [WIDTH-1:0] j;
        logic [WIDTH-1:0] k;
        logic             tc;
        logic             syn;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    int   m_cnt;
    bit   m_init;
    bit   m_sync;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus and queue what the outputs must show.
    task automatic cycle(input bit r, input bit e, input bit u, input bit l, input int lv);
        exp_t x;
        int   nx;
        @(negedge clk);
        rst_n    = r;
        en       = e;
        up_dn    = u;
        load     = l;
        load_val = lv[WIDTH-1:0];
        if (!r) begin
            m_cnt  = 0;
            m_init = 1'b1;
            m_sync = 1'b0;
        end
        if (l)          nx = (lv > MOD - 1) ? MOD - 1 : lv;
        else if (e && u) nx = (m_cnt + 1) % MOD;
        else if (e)     nx = (m_cnt + MOD - 1) % MOD;
        else            nx = m_cnt;
        x.cnt = m_cnt[WIDTH-1:0];
        x.syn = m_sync;
        x.tc  = e && !l && ((u && m_cnt == MOD - 1) || (!u && m_cnt == 0));
        if (!r) begin
            x.j = '0;
            x.k = '0;
        end else if (m_init || l) begin
            x.j = nx[WIDTH-1:0];
            x.k = ~nx[WIDTH-1:0];
        end else begin
            x.j = m_cnt[WIDTH-1:0] ^ nx[WIDTH-1:0];
            x.k = x.j;
        end
        q.push_back(x);
        if (r) begin
            m_cnt = nx;
            if (m_init) begin
                m_init = 1'b0;
                m_sync = 1'b1;
            end
        end
    endtask

    // Monitor: samples mid-cycle, well away from the rising edge.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                x = q.pop_front();
                check("count",  32'(count),  32'(x.cnt));
                check("j_out",  32'(j_out),  32'(x.j));
                check("k_out",  32'(k_out),  32'(x.k));
                check("tc",     32'(tc),     32'(x.tc));
                check("synced", 32'(synced), 32'(x.syn));
                if (x.syn) check("bank", 32'(bank), 32'(x.cnt));
            end
        end
    end

    initial begin
        #200000;
        n_bad++;
        $display("FAIL timeout: got running expected finished");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        rst_n = 1'b0; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = '0;
        m_cnt = 0; m_init = 1'b1; m_sync = 1'b0;

        repeat (3) cycle(1'b0, 1'b0, 1'b1, 1'b0, 0);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 0);
        repeat (12) cycle(1'b1, 1'b1, 1'b1, 1'b0, 0);

        cycle(1'b1, 1'b0, 1'b1, 1'b1, 0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 0);

        cycle(1'b1, 1'b1, 1'b1, 1'b1, 6);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 13);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 0);

        cycle(1'b1, 1'b0, 1'b1, 1'b1, 4);
        repeat (5) cycle(1'b1, 1'b0, 1'b0, 1'b0, 0);

        repeat (2) cycle(1'b0, 1'b0, 1'b1, 1'b0, 0);
        cycle(1'b1, 1'b0, 1'b1, 1'b1, 3);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 0);

        cycle(1'b1, 1'b0, 1'b1, 1'b1, 7);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 0);
        repeat (2) cycle(1'b0, 1'b0, 1'b1, 1'b0, 0);
        repeat (2) cycle(1'b1, 1'b1, 1'b1, 1'b0, 0);

        repeat (400) begin
            cycle($urandom_range(0, 59) != 0,
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 1) == 1,
                  $urandom_range(0, 7) == 0,
                  int'($urandom_range(0, 15)));
        end

        repeat (2) @(negedge clk);
        #3;
        check("queue_drain", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/jk_mod_counter_drv.md
Name: jk_mod_counter_drv

Overview:
- Programmable modulo-MOD up/down synchronous counter that drives a downstream bank of WIDTH single-bit JK flip-flops, one flip-flop per count bit, all clocked from the same clk.
- Each cycle it presents per-bit J/K excitation so that, at the next clk edge, the JK bank's q bits equal this block's internal count.
- It also exposes the count and a terminal-count flag for cascading.

Parameters:
- WIDTH, 4, bit width of count and of the J/K excitation vectors.
- MOD, 10, counter modulus, 2 <= MOD <= 2**WIDTH; the count ranges 0..MOD-1.

Ports:
- clk  input  1  rising-edge clock, shared with the downstream JK flip-flop bank.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  count enable.
- up_dn  input  1  direction: 1 = up, 0 = down.
- load  input  1  synchronous parallel load request.
- load_val  input  WIDTH  value to load.
- count  output  WIDTH  registered current count.
- j_out  output  WIDTH  per-bit J excitation for the JK bank (combinational).
- k_out  output  WIDTH  per-bit K excitation for the JK bank (combinational).
- tc  output  1  terminal count (combinational).
- synced  output  1  registered; 1 once the JK bank is guaranteed to equal count.

Behaviour:
- Reset (rst_n=0, asynchronous): count=0, state=INIT, synced=0.
  - j_out and k_out are forced to all-zeros while rst_n=0, so the JK bank holds.
- nxt, the next count, is computed every cycle with this priority:
  - load=1: nxt = load_val if load_val <= MOD-1, else MOD-1 (clamped).
  - else en=1, up_dn=1: nxt = count+1, wrapping MOD-1 -> 0.
  - else en=1, up_dn=0: nxt = count-1, wrapping 0 -> MOD-1.
  - else: nxt = count.
- count <= nxt on every rising clk edge when rst_n=1. There is one cycle of latency from inputs to count.
- State machine: two states, INIT and RUN.
  - INIT is entered on reset and lasts exactly one clk edge after rst_n deasserts. It then moves to RUN unconditionally.
  - RUN holds until the next reset.
  - synced <= 1 on the INIT->RUN edge, so synced=1 coincides with the first cycle in which count equals the bank's q.
- Excitation encoding in INIT (force mode), needed because the JK bank has no reset and its contents are unknown:
  - j_out = nxt, k_out = ~nxt.
  - Each JK bit is driven to set (10) or clear (01), giving q = nxt after the edge regardless of prior state.
- Excitation encoding in RUN, load=1 (force mode): same as INIT, j_out = nxt, k_out = ~nxt.
- Excitation encoding in RUN, load=0 (toggle mode):
  - t = count XOR nxt; j_out = t, k_out = t.
  - Each bit either holds (00) or toggles (11).
  - en=0 therefore gives j_out = k_out = 0.
- Inputs are honoured in INIT: a load or count request in the first cycle after reset is not lost.
- tc = en & ~load & ((up_dn & count==MOD-1) | (~up_dn & count==0)).
  - tc is 1 exactly in a cycle whose edge wraps.
  - A load suppresses tc.
- All arithmetic is done in WIDTH+1 bits, with no overflow at MOD = 2**WIDTH.
- Reset asserted mid-run: everything returns immediately to the reset values, and the INIT force cycle repeats after release.
- Invariant, checked by assertion: in RUN, the q bits of the shadow JK bank equal count on every cycle.

Test Plan:
- Reset sync:
  - Stimulus: preload the shadow JK bank with 4'b1011, pulse rst_n low, release with en=0.
  - Required: during reset j_out=0 and k_out=0.
  - Required: first post-reset cycle j_out=0000, k_out=1111.
  - Required: after that edge, bank=0, synced=1, count=0.
- Up count and wrap:
  - Stimulus: en=1, up_dn=1 for 12 cycles.
  - Required: count runs 0,1,...,9,0,1; tc=1 only while count=9.
  - Required: j_out=k_out=4'b1001 at the 9->0 step; the bank matches every cycle.
- Down wrap:
  - Stimulus: from count=0, en=1, up_dn=0.
  - Required: count becomes 9; tc=1 in the count=0 cycle; j_out=k_out=4'b1001.
- Load priority and clamp:
  - Stimulus: en=1, up_dn=1, load=1, load_val=6.
  - Required: count=6, tc=0, j_out=0110, k_out=1001.
  - Stimulus: load_val=13.
  - Required: count=9.
- Hold:
  - Stimulus: en=0, load=0 for 5 cycles at count=4.
  - Required: count stays 4, j_out=k_out=0, tc=0.
- Load in INIT and mid-run reset:
  - Stimulus: release rst_n with load=1, load_val=3.
  - Required: count=3, bank=3, synced=1.
  - Stimulus: assert rst_n at count=7, between clk edges.
  - Required: count=0 immediately, synced=0.
